// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the matrix loader slice.
//   WORDS       : elements per 4x4 matrix
//   ELEM_W      : element width in bits
//   MAT_W       : packed matrix width (WORDS * ELEM_W)
//   LOAD_READS  : reads issued per operation (A then B)
//   state_t     : loader FSM state encoding
//   mat_word()  : extract element k (row k/4, col k%4) from a packed matrix
package matrix_loader_pkg;

  localparam int WORDS      = 16;
  localparam int ELEM_W     = 16;
  localparam int MAT_W      = WORDS * ELEM_W;
  localparam int LOAD_READS = 2 * WORDS;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_MULT_REQ  = 3'd2,
    ST_MULT_WAIT = 3'd3,
    ST_STORE     = 3'd4,
    ST_FIN       = 3'd5
  } state_t;

  // Element k lives at bits k*16+15 : k*16.
  function automatic logic [ELEM_W-1:0] mat_word(input logic [MAT_W-1:0] m,
                                                 input logic [3:0]       k);
    return m[k*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Bundle of every non-clock signal of the matrix loader.
//   control : start, src_a, src_b, dst (in) / busy, done, error (out)
//   memory  : mem_addr, mem_rd, mem_wr, mem_wdata (out) / mem_rdata (in)
//   mult    : m1, m2, mult_en (out) / mult_done, m_out (in)
// Memory strobes: mem_rd in cycle N returns mem_rdata in cycle N+1;
// mem_wr qualifies mem_addr/mem_wdata in the same cycle. There is no
// back-pressure: the memory must accept one access per cycle.
// modport master = loader side, modport slave = environment side.
interface matrix_loader_if #(
  parameter int ADDR_W = 8
);

  logic                               start;
  logic [ADDR_W-1:0]                  src_a;
  logic [ADDR_W-1:0]                  src_b;
  logic [ADDR_W-1:0]                  dst;
  logic [ADDR_W-1:0]                  mem_addr;
  logic                               mem_rd;
  logic [matrix_loader_pkg::ELEM_W-1:0] mem_rdata;
  logic                               mem_wr;
  logic [matrix_loader_pkg::ELEM_W-1:0] mem_wdata;
  logic [matrix_loader_pkg::MAT_W-1:0]  m1;
  logic [matrix_loader_pkg::MAT_W-1:0]  m2;
  logic                               mult_en;
  logic                               mult_done;
  logic [matrix_loader_pkg::MAT_W-1:0]  m_out;
  logic                               busy;
  logic                               done;
  logic                               error;

  modport master (
    input  start, src_a, src_b, dst, mem_rdata, mult_done, m_out,
    output mem_addr, mem_rd, mem_wr, mem_wdata, m1, m2, mult_en,
           busy, done, error
  );

  modport slave (
    output start, src_a, src_b, dst, mem_rdata, mult_done, m_out,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, m1, m2, mult_en,
           busy, done, error
  );

endinterface

// File: rtl/matrix_pack.sv
// Shift-in register assembling 16 elements into one packed matrix.
//   clk      : clock
//   reset    : asynchronous active-low reset, clears the matrix
//   shift_en : accept din this cycle
//   din      : incoming element
//   data     : packed matrix; the first element shifted in ends at bits 15:0
// Holds its value whenever shift_en is low.
module matrix_pack
  import matrix_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [ELEM_W-1:0] din,
  output logic [MAT_W-1:0]  data
);

  // New elements enter at the top and walk down, so after 16 shifts
  // element k sits at bits k*16+15 : k*16.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {din, data[MAT_W-1:ELEM_W]};
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Load-multiply-store sequencer for a 4x4 16-bit matrix multiplier.
// Reads A (16 words at src_a) and B (16 words at src_b), hands them to an
// external multiplier as m1/m2, waits for mult_done (bounded by TIMEOUT),
// then writes the 16-word product to dst.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : matrix_loader_if.master (control, memory, multiplier)
//   state_dbg  : current FSM state
// Parameters: ADDR_W (word address width), TIMEOUT (MULT_WAIT cycle bound,
// must be >= 1).
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  matrix_loader_if.master bus,
  output state_t          state_dbg
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q, state_d;
  logic [5:0]          cnt_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [ADDR_W-1:0]   src_a_q, src_b_q, dst_q;
  logic [MAT_W-1:0]    result_q;
  logic                err_q;

  logic                load_last, store_last, wait_timeout;
  logic                shift_a, shift_b;
  logic [MAT_W-1:0]    m1_w, m2_w;

  logic [ADDR_W-1:0]   mem_addr_c;
  logic                mem_rd_c, mem_wr_c, mult_en_c, done_c, error_c;
  logic [ELEM_W-1:0]   mem_wdata_c;

  assign load_last    = (cnt_q == 6'(LOAD_READS));
  assign store_last   = (cnt_q == 6'(WORDS - 1));
  assign wait_timeout = (wcnt_q == WCNT_W'(TIMEOUT - 1));

  // Read data trails its strobe by one cycle, so LOAD count c captures the
  // word requested at count c-1: counts 1..16 feed A, 17..32 feed B.
  assign shift_a = (state_q == ST_LOAD) && (cnt_q != 6'd0) && (cnt_q <= 6'd16);
  assign shift_b = (state_q == ST_LOAD) && (cnt_q >= 6'd17);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (bus.start) state_d = ST_LOAD;
      ST_LOAD:      if (load_last) state_d = ST_MULT_REQ;
      ST_MULT_REQ:  state_d = ST_MULT_WAIT;
      ST_MULT_WAIT: begin
        if (bus.mult_done)      state_d = ST_STORE;
        else if (wait_timeout)  state_d = ST_FIN;
      end
      ST_STORE:     if (store_last) state_d = ST_FIN;
      ST_FIN:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- outputs
  always_comb begin
    mem_addr_c  = '0;
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_wdata_c = '0;
    mult_en_c   = 1'b0;
    done_c      = 1'b0;
    error_c     = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        // Count 32 is the capture-only cycle; reads stop at 31.
        if (!cnt_q[5]) begin
          mem_rd_c   = 1'b1;
          mem_addr_c = (cnt_q[4] ? src_b_q : src_a_q) + ADDR_W'(cnt_q[3:0]);
        end
      end
      ST_MULT_REQ: mult_en_c = 1'b1;
      ST_STORE: begin
        mem_wr_c    = 1'b1;
        mem_addr_c  = dst_q + ADDR_W'(cnt_q[3:0]);
        mem_wdata_c = mat_word(result_q, cnt_q[3:0]);
      end
      ST_FIN: begin
        done_c  = 1'b1;
        error_c = err_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_rd    = mem_rd_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mult_en   = mult_en_c;
  assign bus.done      = done_c;
  assign bus.error     = error_c;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.m1        = m1_w;
  assign bus.m2        = m2_w;
  assign state_dbg     = state_q;

  // -------------------------------------------------- datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      wcnt_q   <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.start) begin
        src_a_q <= bus.src_a;
        src_b_q <= bus.src_b;
        dst_q   <= bus.dst;
        err_q   <= 1'b0;
      end

      // One counter serves LOAD and STORE; it restarts on every state change.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == ST_LOAD || state_q == ST_STORE) begin
        cnt_q <= cnt_q + 6'd1;
      end

      if (state_q == ST_MULT_WAIT && state_d == ST_MULT_WAIT) begin
        wcnt_q <= wcnt_q + WCNT_W'(1);
      end else begin
        wcnt_q <= '0;
      end

      if (state_q == ST_MULT_WAIT && bus.mult_done) begin
        result_q <= bus.m_out;
      end

      if (state_q == ST_MULT_WAIT && !bus.mult_done && wait_timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  matrix_pack u_pack_a (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_a),
    .din      (bus.mem_rdata),
    .data     (m1_w)
  );

  matrix_pack u_pack_b (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_b),
    .din      (bus.mem_rdata),
    .data     (m2_w)
  );

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;
  import matrix_loader_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 255;

  // ------------------------------------------------ clock / reset block
  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;

  always #5 clk = ~clk;

  matrix_loader_if #(.ADDR_W(ADDR_W)) bus ();

  matrix_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ------------------------------------------------ scoreboard state
  int              checks = 0;
  int              passed = 0;
  logic [15:0]     mem [0:255];
  logic [7:0]      rd_log [$];
  logic [7:0]      wa_log [$];
  logic [15:0]     wd_log [$];
  logic [15:0]     exp_q  [$];
  int              both_cnt = 0;
  logic            req_v = 1'b0;
  logic [7:0]      req_a = '0;
  int              mult_cd = 0;
  logic            mult_auto = 1'b1;
  logic [15:0]     mat_a [16];
  logic [15:0]     mat_b [16];

  function automatic logic [255:0] mat_mul(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    logic [15:0]  acc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc + 16'(x[(i*4+k)*16 +: 16] * y[(k*4+j)*16 +: 16]);
        r[(i*4+j)*16 +: 16] = acc;
      end
    end
    return r;
  endfunction

  // Memory, bus monitor and multiplier model, all sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_rd && bus.mem_wr) both_cnt++;
    if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
    if (bus.mem_wr) begin
      wa_log.push_back(bus.mem_addr);
      wd_log.push_back(bus.mem_wdata);
      mem[bus.mem_addr] = bus.mem_wdata;
    end
    req_v = bus.mem_rd;
    req_a = bus.mem_addr;
    // Multiplier answers three cycles after the mult_en cycle.
    bus.mult_done = 1'b0;
    if (mult_cd > 0) begin
      mult_cd--;
      if (mult_cd == 0) begin
        bus.m_out     = mat_mul(bus.m1, bus.m2);
        bus.mult_done = 1'b1;
      end
    end
    if (bus.mult_en && mult_auto) mult_cd = 3;
  end

  always @(posedge clk) begin
    #1;
    if (req_v) bus.mem_rdata = mem[req_a];
  end

  // ------------------------------------------------ driver tasks
  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    exp_q.delete();
  endtask

  task automatic write_mats(input logic [7:0] a_base, input logic [7:0] b_base);
    for (int k = 0; k < 16; k++) begin
      mem[8'(a_base + k)] = mat_a[k];
      mem[8'(b_base + k)] = mat_b[k];
    end
  endtask

  // Called on a falling edge; lat = 1 is the first cycle after the start edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                        input int limit, output int lat, output logic seen,
                        output logic err_seen);
    bus.src_a = a;
    bus.src_b = b;
    bus.dst   = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    seen = 1'b0;
    err_seen = 1'b0;
    while (!seen && lat < limit) begin
      if (bus.done) begin
        seen = 1'b1;
        err_seen = bus.error;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    checks++; if ({bus.mem_rd, bus.mem_wr, bus.mult_en, bus.done, bus.error} !== 5'b0)
      $display("FAIL reset_strobes got=%b exp=00000", {bus.mem_rd, bus.mem_wr, bus.mult_en, bus.done, bus.error}); else passed++;
    checks++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0) $display("FAIL reset_bus got=%h/%h exp=00/0000", bus.mem_addr, bus.mem_wdata); else passed++;
    checks++; if (bus.m1 !== '0 || bus.m2 !== '0) $display("FAIL reset_m1m2 got=%h %h exp=0", bus.m1, bus.m2); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL reset_release_state got=%0d exp=%0d", state_dbg, ST_IDLE); else passed++;
  endtask

  task automatic test_identity();
    int lat; logic seen, err; logic [255:0] e1, e2; logic [15:0] got;
    for (int k = 0; k < 16; k++) begin
      mat_a[k] = (k % 5 == 0) ? 16'd1 : 16'd0;
      mat_b[k] = 16'(k + 1);
      e1[k*16 +: 16] = mat_a[k];
      e2[k*16 +: 16] = mat_b[k];
      exp_q.push_back(16'(k + 1));
    end
    write_mats(8'h10, 8'h30);
    clear_logs();
    for (int k = 0; k < 16; k++) exp_q.push_back(16'(k + 1));
    run_op(8'h10, 8'h30, 8'h50, 100, lat, seen, err);
    checks++; if (!seen || lat !== 54) $display("FAIL ident_latency got=%0d seen=%b exp=54", lat, seen); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL ident_error got=%b exp=0", err); else passed++;
    checks++; if (rd_log.size() !== 32) $display("FAIL ident_reads got=%0d exp=32", rd_log.size()); else passed++;
    if (rd_log.size() == 32) begin
      checks++; if (rd_log[0] !== 8'h10 || rd_log[15] !== 8'h1F || rd_log[16] !== 8'h30 || rd_log[31] !== 8'h3F)
        $display("FAIL ident_read_addr got=%h %h %h %h exp=10 1f 30 3f", rd_log[0], rd_log[15], rd_log[16], rd_log[31]); else passed++;
    end
    checks++; if (wa_log.size() !== 16) $display("FAIL ident_writes got=%0d exp=16", wa_log.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      got = (i < wd_log.size()) ? wd_log[i] : 16'hxxxx;
      checks++;
      if (got !== exp_q[i] || i >= wa_log.size() || wa_log[i] !== 8'(8'h50 + i))
        $display("FAIL ident_write%0d got=%h@%h exp=%h@%h", i, got, (i < wa_log.size()) ? wa_log[i] : 8'hxx, exp_q[i], 8'(8'h50 + i));
      else passed++;
    end
    checks++; if (bus.m1 !== e1) $display("FAIL ident_m1 got=%h exp=%h", bus.m1, e1); else passed++;
    checks++; if (bus.m2 !== e2) $display("FAIL ident_m2 got=%h exp=%h", bus.m2, e2); else passed++;
    checks++; if (state_dbg !== ST_IDLE || bus.busy !== 1'b0) $display("FAIL ident_idle got=%0d/%b exp=%0d/0", state_dbg, bus.busy, ST_IDLE); else passed++;
  endtask

  task automatic test_wrap();
    int lat; logic seen, err; logic [255:0] e1; logic [7:0] ea; logic [15:0] got;
    for (int k = 0; k < 16; k++) begin
      mat_a[k] = 16'hA000 + 16'(k);
      mat_b[k] = (k % 5 == 0) ? 16'd1 : 16'd0;
      e1[k*16 +: 16] = mat_a[k];
    end
    write_mats(8'hFA, 8'h20);
    clear_logs();
    for (int k = 0; k < 16; k++) exp_q.push_back(16'hA000 + 16'(k));
    run_op(8'hFA, 8'h20, 8'h60, 100, lat, seen, err);
    checks++; if (!seen || lat !== 54) $display("FAIL wrap_latency got=%0d exp=54", lat); else passed++;
    for (int i = 0; i < 16; i++) begin
      ea = (i < 6) ? 8'(8'hFA + i) : 8'(i - 6);
      checks++;
      if (i >= rd_log.size() || rd_log[i] !== ea)
        $display("FAIL wrap_read%0d got=%h exp=%h", i, (i < rd_log.size()) ? rd_log[i] : 8'hxx, ea);
      else passed++;
    end
    checks++; if (bus.m1 !== e1) $display("FAIL wrap_m1 got=%h exp=%h", bus.m1, e1); else passed++;
    for (int i = 0; i < 16; i++) begin
      got = (i < wd_log.size()) ? wd_log[i] : 16'hxxxx;
      checks++;
      if (got !== exp_q[i]) $display("FAIL wrap_write%0d got=%h exp=%h", i, got, exp_q[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int k; int pulses; int done_k;
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
      mat_b[i] = 16'(i + 1);
    end
    write_mats(8'h10, 8'h30);
    clear_logs();
    bus.src_a = 8'h10; bus.src_b = 8'h30; bus.dst = 8'h70;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1; pulses = 0; done_k = 0;
    while (k < 90) begin
      if (bus.done) begin pulses++; done_k = k; end
      if (k == 55) begin
        checks++; if (state_dbg !== ST_IDLE) $display("FAIL busy_fin_start got=%0d exp=%0d", state_dbg, ST_IDLE); else passed++;
      end
      // Start during LOAD, during STORE, and in the FIN cycle.
      bus.start = (k == 5) || (k == 40) || (k == 54);
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    checks++; if (pulses !== 1 || done_k !== 54) $display("FAIL busy_done got=%0d@%0d exp=1@54", pulses, done_k); else passed++;
    checks++; if (wa_log.size() !== 16) $display("FAIL busy_writes got=%0d exp=16", wa_log.size()); else passed++;
    checks++; if (rd_log.size() !== 32) $display("FAIL busy_reads got=%0d exp=32", rd_log.size()); else passed++;
  endtask

  task automatic test_timeout();
    int lat; logic seen, err;
    clear_logs();
    mult_auto = 1'b0;
    run_op(8'h10, 8'h30, 8'h90, 400, lat, seen, err);
    mult_auto = 1'b1;
    checks++; if (!seen || lat !== 35 + TIMEOUT) $display("FAIL timeout_latency got=%0d seen=%b exp=%0d", lat, seen, 35 + TIMEOUT); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL timeout_error got=%b exp=1", err); else passed++;
    checks++; if (wa_log.size() !== 0) $display("FAIL timeout_writes got=%0d exp=0", wa_log.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int k; int n_rd; logic done_seen; int lat; logic seen, err; logic [15:0] got;
    clear_logs();
    bus.src_a = 8'h10; bus.src_b = 8'h30; bus.dst = 8'h80;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (k < 10) begin @(negedge clk); k++; end
    reset = 1'b0;
    #1;
    checks++; if (state_dbg !== ST_IDLE || bus.busy !== 1'b0) $display("FAIL rstmid_state got=%0d/%b exp=%0d/0", state_dbg, bus.busy, ST_IDLE); else passed++;
    checks++; if (bus.mem_rd !== 1'b0 || bus.mem_addr !== 8'h00) $display("FAIL rstmid_read got=%b@%h exp=0@00", bus.mem_rd, bus.mem_addr); else passed++;
    checks++; if (bus.m1 !== '0 || bus.m2 !== '0) $display("FAIL rstmid_m1m2 got=%h %h exp=0", bus.m1, bus.m2); else passed++;
    n_rd = rd_log.size();
    done_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.done) done_seen = 1'b1; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.done) done_seen = 1'b1; end
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL rstmid_idle got=%0d exp=%0d", state_dbg, ST_IDLE); else passed++;
    checks++; if (rd_log.size() !== n_rd || wa_log.size() !== 0 || done_seen !== 1'b0)
      $display("FAIL rstmid_quiet got=rd%0d wr%0d done%b exp=rd%0d wr0 done0", rd_log.size(), wa_log.size(), done_seen, n_rd); else passed++;
    clear_logs();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'(i + 1));
    run_op(8'h10, 8'h30, 8'h80, 100, lat, seen, err);
    checks++; if (!seen || lat !== 54 || err !== 1'b0) $display("FAIL rstmid_rerun got=%0d/%b exp=54/0", lat, err); else passed++;
    for (int i = 0; i < 16; i++) begin
      got = (i < wd_log.size()) ? wd_log[i] : 16'hxxxx;
      checks++;
      if (got !== exp_q[i]) $display("FAIL rstmid_write%0d got=%h exp=%h", i, got, exp_q[i]); else passed++;
    end
  endtask

  task automatic test_overlap();
    int lat; logic seen, err;
    for (int k = 0; k < 16; k++) begin
      mat_a[k] = (k % 5 == 0) ? 16'd2 : 16'd0;
      mat_b[k] = 16'd3;
    end
    write_mats(8'hC0, 8'hD0);
    clear_logs();
    run_op(8'hC0, 8'hD0, 8'hC0, 100, lat, seen, err);
    checks++; if (!seen || lat !== 54) $display("FAIL overlap_latency got=%0d exp=54", lat); else passed++;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (mem[8'(8'hC0 + k)] !== 16'd6) $display("FAIL overlap_word%0d got=%h exp=0006", k, mem[8'(8'hC0 + k)]); else passed++;
    end
  endtask

  // ------------------------------------------------ sequence + report
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    bus.start = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.dst = '0;
    bus.mem_rdata = '0; bus.mult_done = 1'b0; bus.m_out = '0;
    test_reset();
    test_identity();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_overlap();
    checks++; if (both_cnt !== 0) $display("FAIL rd_wr_overlap got=%0d exp=0", both_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ADDR_W, default 8, memory word-address width.
REQ-002 Parameter TIMEOUT, default 255, maximum MULT_WAIT cycles before abort.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one load-multiply-store operation.
REQ-007 src_a  input  ADDR_W  base word address of matrix A.
REQ-008 src_b  input  ADDR_W  base word address of matrix B.
REQ-009 dst  input  ADDR_W  base word address for the result.
REQ-010 mem_addr  output  ADDR_W  memory word address.
REQ-011 mem_rd  output  1  read strobe; mem_rdata is valid on the following cycle.
REQ-012 mem_rdata  input  16  read data.
REQ-013 mem_wr  output  1  write strobe; mem_addr and mem_wdata are valid in the same cycle.
REQ-014 mem_wdata  output  16  write data.
REQ-015 m1, m2  output  256  packed operands to matrix_mult.
REQ-016 mult_en  output  1  enable to matrix_mult.
REQ-017 mult_done  input  1  done flag from matrix_mult.
REQ-018 m_out  input  256  product from matrix_mult.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle completion pulse.
REQ-021 error  output  1  high with done when the operation was aborted by timeout.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, MULT_REQ, MULT_WAIT, STORE, FIN.
REQ-023 IDLE->LOAD SHALL occur when start=1 at a clock edge; src_a, src_b and dst SHALL be latched at that edge.
REQ-024 In LOAD, mem_rd SHALL be high for 32 consecutive cycles: addresses src_a+0..15, then src_b+0..15.
REQ-025 LOAD SHALL last 33 cycles, with the last read datum captured in the 33rd.
REQ-026 Word k (0..15) of each matrix SHALL map to row k/4, col k%4, at bits k*16+15:k*16 of m1 (A) or m2 (B).
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-028 MULT_REQ SHALL last exactly 1 cycle with mult_en=1; mult_en SHALL be 0 in all other states.
REQ-029 MULT_WAIT SHALL sample mult_done from its first cycle; on mult_done=1, m_out SHALL be latched into a result register and the FSM SHALL go to STORE.
REQ-030 If TIMEOUT cycles pass in MULT_WAIT without mult_done, the FSM SHALL go to FIN with error=1, and no writes SHALL be issued.
REQ-031 STORE SHALL assert mem_wr for 16 consecutive cycles, writing result word k to dst+k.
REQ-032 FIN SHALL last 1 cycle with done=1, then return to IDLE.
REQ-033 Minimum latency from the start edge to the done pulse SHALL be 52 cycles.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 start=1 in the FIN cycle SHALL be ignored; a new operation requires start while in IDLE.
REQ-036 Overlap of dst with src_a or src_b SHALL be legal, since all reads finish before any write.
REQ-037 m1 and m2 SHALL hold their values from LOAD completion until the next LOAD.
REQ-038 mem_rd and mem_wr SHALL never be high in the same cycle.

Reset
REQ-039 While reset=0, all outputs, m1, m2, the result register and all counters SHALL be 0, and the FSM SHALL be in IDLE.
REQ-040 Reset asserted mid-operation SHALL abort the operation immediately, with no further mem_rd or mem_wr and no done pulse.

Structure
REQ-041 A shared package SHALL hold the FSM state encoding, the constant WORDS=16, and the element width 16.
REQ-042 One sub-module, matrix_pack, SHALL be a shift-in register assembling 16 sixteen-bit words into 256 bits; it SHALL be instantiated twice (A and B).

Verification
REQ-043 Identity test: A = identity, B = words 1..16, multiplier model done after 3 cycles -> dst+0..15 receive 1..16, and done is asserted 54 cycles after start.
REQ-044 Wrap test: src_a=8'hFA -> reads at FA..FF, then 00..09, and m1 is packed correctly.
REQ-045 Busy start test: start pulsed during LOAD and again during STORE -> exactly one done pulse and one set of 16 writes.
REQ-046 Timeout test: mult_done held at 0 -> done=1 and error=1 at cycle 35+TIMEOUT, and zero mem_wr cycles.
REQ-047 Reset test: reset=0 at LOAD cycle 10 -> all outputs 0 the same cycle, IDLE after release, and the next start completes normally.
REQ-048 Overlap test: dst=src_a with A = 2*identity, B = all 3 -> dst region holds all 6 after done.
